// File: rtl/lc3_mem_ctrl.sv
// Purpose: LC-3 MAR/MDR memory stage driving an async-read RAM; optional LC3_MMIO_EN adds DDR/DSR display registers.
// Latency: MIO_EN sampled at edge 0 -> R pulses in cycle WAIT_CYCLES+2; back-to-back accesses cost one IDLE cycle.
// Backpressure: BUSY high in ACCESS/DONE; LD_MAR, LD_MDR, MIO_EN and R_W are ignored while busy.
module lc3_mem_ctrl #(
    parameter int ADDR_SIZE   = 16,
    parameter int DATA_SIZE   = 16,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic [DATA_SIZE-1:0] BUS,
    input  logic                 LD_MAR,
    input  logic                 LD_MDR,
    input  logic                 MIO_EN,
    input  logic                 R_W,
    output logic [ADDR_SIZE-1:0] MAR_OUT,
    output logic [DATA_SIZE-1:0] MDR_OUT,
    output logic                 R,
    output logic                 BUSY,
    output logic                 MEM_WE,
    output logic [ADDR_SIZE-1:0] MEM_ADDRESS,
    output logic [DATA_SIZE-1:0] MEM_DATA_IN,
`ifdef LC3_MMIO_EN
    output logic [7:0]           DDR_DATA,
    output logic                 DDR_VALID,
`endif
    input  logic [DATA_SIZE-1:0] MEM_DATA_OUT
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_t                 state;
    state_t                 state_nxt;
    logic [3:0]             wait_cnt;
    logic                   op_write;
    logic [ADDR_SIZE-1:0]   mar;
    logic [DATA_SIZE-1:0]   mdr;
    logic                   last_access;
    logic                   ram_we;
    logic [DATA_SIZE-1:0]   read_dat;

    assign last_access = (state == ACCESS) && (wait_cnt == 4'd0);

`ifdef LC3_MMIO_EN
    localparam logic [ADDR_SIZE-1:0] DDR_ADDR = ADDR_SIZE'(16'hFE06);
    localparam logic [ADDR_SIZE-1:0] DSR_ADDR = ADDR_SIZE'(16'hFE04);
    localparam logic [DATA_SIZE-1:0] DSR_RDY  = DATA_SIZE'(16'h8000);

    logic is_ddr;
    logic is_dsr;

    assign is_ddr   = (mar == DDR_ADDR);
    assign is_dsr   = (mar == DSR_ADDR);
    // Display registers never reach the RAM: writes to DDR are diverted, DSR reads always ready.
    assign ram_we   = op_write && !is_ddr;
    assign read_dat = is_dsr ? DSR_RDY : MEM_DATA_OUT;

    // Capture the display byte with the last ACCESS edge so DDR_VALID lines up with R.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            DDR_DATA  <= 8'h00;
            DDR_VALID <= 1'b0;
        end else begin
            DDR_VALID <= last_access && op_write && is_ddr;
            if (last_access && op_write && is_ddr) begin
                DDR_DATA <= mdr[7:0];
            end
        end
    end
`else
    assign ram_we   = op_write;
    assign read_dat = MEM_DATA_OUT;
`endif

    // State register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: DONE always returns to IDLE, giving one IDLE gap between accesses.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (MIO_EN) state_nxt = ACCESS;
            ACCESS:  if (wait_cnt == 4'd0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Wait-state counter and operation latch, loaded when an access starts.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wait_cnt <= 4'd0;
            op_write <= 1'b0;
        end else if (state == IDLE && MIO_EN) begin
            wait_cnt <= WAIT_INIT;
            op_write <= R_W;
        end else if (state == ACCESS && wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
        end
    end

    // MAR/MDR: bus loads only in IDLE so the RAM sees stable address/data; reads land in MDR on the last ACCESS edge.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            mar <= '0;
            mdr <= '0;
        end else begin
            if (state == IDLE && LD_MAR) begin
                mar <= BUS[ADDR_SIZE-1:0];
            end
            if (state == IDLE && LD_MDR) begin
                mdr <= BUS;
            end else if (last_access && !op_write) begin
                mdr <= read_dat;
            end
        end
    end

    assign MAR_OUT     = mar;
    assign MDR_OUT     = mdr;
    assign MEM_ADDRESS = mar;
    assign MEM_DATA_IN = mdr;
    assign R           = (state == DONE);
    assign BUSY        = (state != IDLE);
    assign MEM_WE      = (state == ACCESS) && ram_we;

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// Purpose: directed bench for lc3_mem_ctrl with a behavioural async-read RAM.
// Latency: inputs driven and outputs sampled 1ns after each rising edge.
// Backpressure: exercises loads and starts issued while the controller is busy.
module tb_lc3_mem_ctrl;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [15:0] BUS;
    logic        LD_MAR;
    logic        LD_MDR;
    logic        MIO_EN;
    logic        R_W;
    logic [15:0] MAR_OUT;
    logic [15:0] MDR_OUT;
    logic        R;
    logic        BUSY;
    logic        MEM_WE;
    logic [15:0] MEM_ADDRESS;
    logic [15:0] MEM_DATA_IN;
    logic [15:0] MEM_DATA_OUT;
`ifdef LC3_MMIO_EN
    logic [7:0]  DDR_DATA;
    logic        DDR_VALID;
`endif

    int tests = 0;
    int fails = 0;

    logic [15:0] ram [0:65535];

    lc3_mem_ctrl #(
        .ADDR_SIZE  (16),
        .DATA_SIZE  (16),
        .WAIT_CYCLES(1)
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .BUS         (BUS),
        .LD_MAR      (LD_MAR),
        .LD_MDR      (LD_MDR),
        .MIO_EN      (MIO_EN),
        .R_W         (R_W),
        .MAR_OUT     (MAR_OUT),
        .MDR_OUT     (MDR_OUT),
        .R           (R),
        .BUSY        (BUSY),
        .MEM_WE      (MEM_WE),
        .MEM_ADDRESS (MEM_ADDRESS),
        .MEM_DATA_IN (MEM_DATA_IN),
`ifdef LC3_MMIO_EN
        .DDR_DATA    (DDR_DATA),
        .DDR_VALID   (DDR_VALID),
`endif
        .MEM_DATA_OUT(MEM_DATA_OUT)
    );

    always #5 CLK = ~CLK;

    // Asynchronous-read, synchronous-write RAM.
    assign MEM_DATA_OUT = ram[MEM_ADDRESS];
    always @(posedge CLK) begin
        if (MEM_WE) ram[MEM_ADDRESS] <= MEM_DATA_IN;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        ram[16'h0008] = 16'h1026;
        ram[16'h0009] = 16'h1405;
        ram[16'h0020] = 16'h0000;
        RST_N = 1'b0; BUS = '0; LD_MAR = 0; LD_MDR = 0; MIO_EN = 0; R_W = 0;
        tick(); tick();
        chk("rst_mar", MAR_OUT, 0);
        chk("rst_mdr", MDR_OUT, 0);
        chk("rst_r", R, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_we", MEM_WE, 0);
        RST_N = 1'b1;
        tick();

        // 1: write x1234 to x0020
        BUS = 16'h0020; LD_MAR = 1; tick();
        LD_MAR = 0; BUS = 16'h1234; LD_MDR = 1; tick();
        chk("t1_mar", MAR_OUT, 16'h0020);
        chk("t1_mdr", MDR_OUT, 16'h1234);
        LD_MDR = 0; MIO_EN = 1; R_W = 1; tick();
        MIO_EN = 0; R_W = 0;
        chk("t1_c1_we", MEM_WE, 1);
        chk("t1_c1_busy", BUSY, 1);
        chk("t1_c1_r", R, 0);
        chk("t1_c1_addr", MEM_ADDRESS, 16'h0020);
        chk("t1_c1_din", MEM_DATA_IN, 16'h1234);
        tick();
        chk("t1_c2_we", MEM_WE, 1);
        chk("t1_c2_r", R, 0);
        chk("t1_c2_busy", BUSY, 1);
        tick();
        chk("t1_c3_r", R, 1);
        chk("t1_c3_we", MEM_WE, 0);
        chk("t1_c3_busy", BUSY, 1);
        tick();
        chk("t1_idle_r", R, 0);
        chk("t1_idle_busy", BUSY, 0);
        chk("t1_ram", ram[16'h0020], 16'h1234);

        // 2+3: read back x0020; LD_MAR during ACCESS must be ignored
        BUS = 16'h0000; LD_MDR = 1; tick();
        LD_MDR = 0;
        chk("t2_mdr_clr", MDR_OUT, 16'h0000);
        MIO_EN = 1; R_W = 0; tick();
        MIO_EN = 0;
        chk("t2_c1_we", MEM_WE, 0);
        chk("t2_c1_busy", BUSY, 1);
        BUS = 16'h0050; LD_MAR = 1; LD_MDR = 0; tick();
        chk("t3_mar_hold", MAR_OUT, 16'h0020);
        chk("t3_addr_hold", MEM_ADDRESS, 16'h0020);
        chk("t2_c2_we", MEM_WE, 0);
        tick();
        LD_MAR = 0;
        chk("t2_r", R, 1);
        chk("t2_mdr", MDR_OUT, 16'h1234);
        chk("t3_mar_done", MAR_OUT, 16'h0020);
        tick();
        chk("t2_idle_busy", BUSY, 0);

        // 4: back-to-back reads of x0008 then x0009 with MIO_EN held
        BUS = 16'h0008; LD_MAR = 1; MIO_EN = 1; R_W = 0; tick();
        LD_MAR = 0;
        chk("t4_a_mar", MAR_OUT, 16'h0008);
        chk("t4_a_busy", BUSY, 1);
        tick();
        tick();
        chk("t4_a_r", R, 1);
        chk("t4_a_mdr", MDR_OUT, 16'h1026);
        BUS = 16'h0009; LD_MAR = 1; tick();
        chk("t4_gap_busy", BUSY, 0);
        chk("t4_gap_r", R, 0);
        tick();
        LD_MAR = 0; MIO_EN = 0;
        chk("t4_b_busy", BUSY, 1);
        chk("t4_b_mar", MAR_OUT, 16'h0009);
        tick();
        tick();
        chk("t4_b_r", R, 1);
        chk("t4_b_mdr", MDR_OUT, 16'h1405);
        tick();
        chk("t4_end_busy", BUSY, 0);

        // 5: reset in the first ACCESS cycle of a write aborts it
        BUS = 16'hABCD; LD_MDR = 1; tick();
        LD_MDR = 0; BUS = 16'h0030; LD_MAR = 1; MIO_EN = 1; R_W = 1; tick();
        LD_MAR = 0; MIO_EN = 0; R_W = 0;
        chk("t5_we_pre", MEM_WE, 1);
        RST_N = 1'b0;
        #1;
        chk("t5_we", MEM_WE, 0);
        chk("t5_busy", BUSY, 0);
        chk("t5_mar", MAR_OUT, 0);
        chk("t5_mdr", MDR_OUT, 0);
        chk("t5_r", R, 0);
        tick();
        chk("t5_r_held", R, 0);
        RST_N = 1'b1;
        tick();
        chk("t5_r_after", R, 0);
        chk("t5_busy_after", BUSY, 0);

`ifdef LC3_MMIO_EN
        // 6: display registers
        chk("t6_rst_ddr", DDR_VALID, 0);
        BUS = 16'h0041; LD_MDR = 1; tick();
        LD_MDR = 0; BUS = 16'hFE06; LD_MAR = 1; MIO_EN = 1; R_W = 1; tick();
        LD_MAR = 0; MIO_EN = 0; R_W = 0;
        chk("t6_c1_we", MEM_WE, 0);
        chk("t6_c1_vld", DDR_VALID, 0);
        tick();
        chk("t6_c2_we", MEM_WE, 0);
        tick();
        chk("t6_r", R, 1);
        chk("t6_vld", DDR_VALID, 1);
        chk("t6_dat", DDR_DATA, 8'h41);
        tick();
        chk("t6_vld_off", DDR_VALID, 0);
        BUS = 16'hFE04; LD_MAR = 1; MIO_EN = 1; R_W = 0; tick();
        LD_MAR = 0; MIO_EN = 0;
        tick();
        tick();
        chk("t6_dsr_r", R, 1);
        chk("t6_dsr_mdr", MDR_OUT, 16'h8000);
        tick();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
